icache_tag_ctrl: RTL and testbench

ICACHE_TAG_CTRL -- requirements
Module: icache_tag_ctrl

---
 rtl/icache_tag_ctrl_if.sv | 42 ++++
 rtl/icache_tag_ctrl.sv | 95 +++++++++
 tb/tb_icache_tag_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_tag_ctrl_if.sv
// Bundles the lookup, refill, flush and tag RAM signals of the icache tag controller.
// The controller uses slave. The requesters use master. The tag RAM uses ram.
interface icache_tag_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned TAG_WIDTH  = 6
) ();
  logic                  lk_req;
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic [TAG_WIDTH-1:0]  lk_tag;
  logic                  lk_gnt;
  logic                  lk_rvalid;
  logic                  lk_hit;
  logic                  rf_req;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [TAG_WIDTH-1:0]  rf_tag;
  logic                  rf_gnt;
  logic                  flush_req;
  logic                  flush_busy;
  logic                  flush_done;
  logic                  tag_req;
  logic                  tag_write;
  logic [ADDR_WIDTH-1:0] tag_raddr;
  logic [ADDR_WIDTH-1:0] tag_waddr;
  logic [TAG_WIDTH:0]    tag_wdata;
  logic [TAG_WIDTH:0]    tag_rdata;

  modport master (
    output lk_req, lk_addr, lk_tag, rf_req, rf_addr, rf_tag, flush_req,
    input  lk_gnt, lk_rvalid, lk_hit, rf_gnt, flush_busy, flush_done
  );

  modport slave (
    input  lk_req, lk_addr, lk_tag, rf_req, rf_addr, rf_tag, flush_req, tag_rdata,
    output lk_gnt, lk_rvalid, lk_hit, rf_gnt, flush_busy, flush_done,
    output tag_req, tag_write, tag_raddr, tag_waddr, tag_wdata
  );

  modport ram (
    input  tag_req, tag_write, tag_raddr, tag_waddr, tag_wdata,
    output tag_rdata
  );
endinterface

// File: rtl/icache_tag_ctrl.sv
// Instruction cache tag controller. It arbitrates flush, refill and lookup access to a
// single-port tag RAM. A RAM word is {valid, tag}.
module icache_tag_ctrl #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  icache_tag_ctrl_if.slave bus
);
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned TW = TAG_WIDTH;
  localparam int unsigned WW = TAG_WIDTH + 1;
  localparam logic [AW-1:0] CNT_LAST = '1;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t         state;
  logic [AW-1:0]  cnt;
  logic [TW-1:0]  lk_tag_q;
  logic           lk_rvalid_q;
  logic           flush_busy_q;
  logic           flush_done_q;
  logic           lk_gnt_c;
  logic           rf_gnt_c;
  logic           idle_free;

  // Fixed priority: an active flush wins, then a new flush request, then refill, then lookup.
  always_comb begin
    idle_free      = (state == IDLE) && !bus.flush_req;
    rf_gnt_c       = idle_free && bus.rf_req;
    lk_gnt_c       = idle_free && !bus.rf_req && bus.lk_req;
    bus.tag_req    = 1'b0;
    bus.tag_write  = 1'b0;
    bus.tag_raddr  = bus.lk_addr;
    bus.tag_waddr  = bus.rf_addr;
    bus.tag_wdata  = {1'b1, bus.rf_tag};
    if (state == FLUSH) begin
      bus.tag_req   = 1'b1;
      bus.tag_write = 1'b1;
      bus.tag_waddr = cnt;
      bus.tag_wdata = WW'(0);
    end else if (rf_gnt_c) begin
      bus.tag_req   = 1'b1;
      bus.tag_write = 1'b1;
    end else if (lk_gnt_c) begin
      bus.tag_req   = 1'b1;
    end
  end

  // The RAM returns read data one cycle after the grant. It is compared against the captured tag.
  always_comb begin
    bus.lk_gnt     = lk_gnt_c;
    bus.rf_gnt     = rf_gnt_c;
    bus.lk_rvalid  = lk_rvalid_q;
    bus.lk_hit     = lk_rvalid_q && bus.tag_rdata[TW] &&
                     (bus.tag_rdata[TW-1:0] == lk_tag_q);
    bus.flush_busy = flush_busy_q;
    bus.flush_done = flush_done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FLUSH;
      cnt          <= '0;
      lk_tag_q     <= '0;
      lk_rvalid_q  <= 1'b0;
      flush_busy_q <= 1'b1;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      lk_rvalid_q  <= lk_gnt_c;
      if (lk_gnt_c) lk_tag_q <= bus.lk_tag;
      case (state)
        IDLE: begin
          if (bus.flush_req) begin
            state        <= FLUSH;
            cnt          <= '0;
            flush_busy_q <= 1'b1;
          end
        end
        FLUSH: begin
          // A flush request seen here is dropped. It does not restart or queue a flush.
          cnt <= cnt + AW'(1);
          if (cnt == CNT_LAST) begin
            state        <= IDLE;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Randomized scoreboard bench for icache_tag_ctrl. The bench also holds a tag RAM model
// with 1-cycle read latency and a reference model of the cache contents.
module tb_icache_tag_ctrl;
  localparam int unsigned AW = 6;
  localparam int unsigned TW = 6;
  localparam int N = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  icache_tag_ctrl_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  icache_tag_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag RAM model: 1-cycle read latency. Read data is random in any cycle not following a read.
  logic [TW:0] mem [N];
  initial for (int i = 0; i < N; i++) mem[i] = (TW+1)'($urandom);
  always @(posedge clk) begin
    if (bus.tag_req && bus.tag_write) mem[bus.tag_waddr] <= bus.tag_wdata;
    if (bus.tag_req && !bus.tag_write) bus.tag_rdata <= mem[bus.tag_raddr];
    else bus.tag_rdata <= (TW+1)'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cache contents, remaining flush cycles and expected lookup results.
  bit          ref_v [N];
  logic [TW-1:0] ref_t [N];
  int          flush_left;
  bit          done_next;
  bit          rv_exp;
  bit          exp_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(bus.flush_busy), 32'd1);
      chk("rst_rvalid", 32'(bus.lk_rvalid), 32'd0);
      chk("rst_hit", 32'(bus.lk_hit), 32'd0);
      chk("rst_done", 32'(bus.flush_done), 32'd0);
      exp_q.delete();
      flush_left = N;
      done_next  = 1'b0;
      rv_exp     = 1'b0;
      for (int i = 0; i < N; i++) ref_v[i] = 1'b0;
    end else begin
      chk("busy", 32'(bus.flush_busy), 32'(flush_left > 0));
      chk("done", 32'(bus.flush_done), 32'(done_next));
      chk("rvalid", 32'(bus.lk_rvalid), 32'(rv_exp));
      done_next = 1'b0;
      rv_exp    = 1'b0;
      if (flush_left > 0) begin
        chk("fl_lk_gnt", 32'(bus.lk_gnt), 32'd0);
        chk("fl_rf_gnt", 32'(bus.rf_gnt), 32'd0);
        chk("fl_wr", 32'({bus.tag_req, bus.tag_write}), 32'd3);
        chk("fl_waddr", 32'(bus.tag_waddr), 32'(N - flush_left));
        chk("fl_wdata", 32'(bus.tag_wdata), 32'd0);
        flush_left--;
        if (flush_left == 0) done_next = 1'b1;
      end else if (bus.flush_req) begin
        chk("fr_gnts", 32'({bus.lk_gnt, bus.rf_gnt, bus.tag_req}), 32'd0);
        for (int i = 0; i < N; i++) ref_v[i] = 1'b0;
        flush_left = N;
      end else if (bus.rf_req) begin
        chk("rf_gnts", 32'({bus.rf_gnt, bus.lk_gnt}), 32'b10);
        chk("rf_wr", 32'({bus.tag_req, bus.tag_write}), 32'd3);
        chk("rf_waddr", 32'(bus.tag_waddr), 32'(bus.rf_addr));
        chk("rf_wdata", 32'(bus.tag_wdata), 32'({1'b1, bus.rf_tag}));
        ref_v[bus.rf_addr] = 1'b1;
        ref_t[bus.rf_addr] = bus.rf_tag;
      end else if (bus.lk_req) begin
        chk("lk_gnts", 32'({bus.rf_gnt, bus.lk_gnt}), 32'b01);
        chk("lk_rd", 32'({bus.tag_req, bus.tag_write}), 32'b10);
        chk("lk_raddr", 32'(bus.tag_raddr), 32'(bus.lk_addr));
        exp_q.push_back(ref_v[bus.lk_addr] && (ref_t[bus.lk_addr] == bus.lk_tag));
        rv_exp = 1'b1;
      end else begin
        chk("idle_gnts", 32'({bus.lk_gnt, bus.rf_gnt, bus.tag_req}), 32'd0);
      end
    end
  end

  // Monitor: takes the oldest expected hit and compares it each time a result appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.lk_rvalid) begin
        if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
        else chk("lk_hit", 32'(bus.lk_hit), 32'(exp_q.pop_front()));
      end else begin
        chk("hit_no_rvalid", 32'(bus.lk_hit), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rf();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.rf_gnt && n < 200);
    chk("rf_grant_timeout", 32'(bus.rf_gnt), 32'd1);
    tick();
    bus.rf_req = 1'b0;
  endtask

  task automatic wait_lk();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.lk_gnt && n < 200);
    chk("lk_grant_timeout", 32'(bus.lk_gnt), 32'd1);
    tick();
    bus.lk_req = 1'b0;
  endtask

  task automatic refill(input logic [AW-1:0] a, input logic [TW-1:0] t);
    bus.rf_req = 1'b1; bus.rf_addr = a; bus.rf_tag = t;
    wait_rf();
  endtask

  task automatic lookup(input logic [AW-1:0] a, input logic [TW-1:0] t);
    bus.lk_req = 1'b1; bus.lk_addr = a; bus.lk_tag = t;
    wait_lk();
  endtask

  task automatic pulse_flush();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
  endtask

  bit lk_seen, rf_seen;
  always @(negedge clk) begin
    lk_seen = bus.lk_gnt;
    rf_seen = bus.rf_gnt;
  end

  initial begin
    checks = 0; failures = 0;
    bus.lk_req = 0; bus.lk_addr = '0; bus.lk_tag = '0;
    bus.rf_req = 0; bus.rf_addr = '0; bus.rf_tag = '0;
    bus.flush_req = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    // A lookup held through the reset flush is granted once the flush completes.
    lookup(6'd9, 6'd0);
    refill(6'd5, 6'h2A);
    lookup(6'd5, 6'h2A);
    lookup(6'd5, 6'h2B);
    // Refill and lookup together: the refill wins. The lookup that follows reads the new tag.
    bus.rf_req = 1; bus.rf_addr = 6'd7; bus.rf_tag = 6'h11;
    bus.lk_req = 1; bus.lk_addr = 6'd7; bus.lk_tag = 6'h11;
    wait_rf();
    wait_lk();
    // Flush with both requesters held. After the flush, refilled entries are gone.
    bus.flush_req = 1;
    bus.rf_req = 1; bus.rf_addr = 6'd20; bus.rf_tag = 6'h3;
    bus.lk_req = 1; bus.lk_addr = 6'd5; bus.lk_tag = 6'h2A;
    tick();
    bus.flush_req = 0;
    wait_rf();
    wait_lk();
    lookup(6'd7, 6'h11);
    lookup(6'd20, 6'h3);
    // A flush request in the middle of a flush is ignored.
    pulse_flush();
    repeat (29) tick();
    pulse_flush();
    repeat (40) tick();
    // Reset in the middle of a flush restarts the flush.
    pulse_flush();
    repeat (20) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (70) tick();
    // Reset while a lookup result is pending.
    refill(6'd3, 6'h15);
    bus.lk_req = 1; bus.lk_addr = 6'd3; bus.lk_tag = 6'h15;
    do @(negedge clk); while (!bus.lk_gnt);
    tick();
    bus.lk_req = 0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (70) tick();
    lookup(6'd3, 6'h15);
    // Random traffic on a small index and tag range, so lookups hit often.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.lk_req || lk_seen) begin
        bus.lk_req  = ($urandom_range(0, 2) != 0);
        bus.lk_addr = AW'($urandom_range(0, 7));
        bus.lk_tag  = TW'($urandom_range(0, 3));
      end
      if (!bus.rf_req || rf_seen) begin
        bus.rf_req  = ($urandom_range(0, 3) == 0);
        bus.rf_addr = AW'($urandom_range(0, 7));
        bus.rf_tag  = TW'($urandom_range(0, 3));
      end
      bus.flush_req = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.lk_req = 0; bus.rf_req = 0; bus.flush_req = 0;
    repeat (80) tick();
    chk("results_outstanding", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
